dac_spi_receiver: RTL and testbench
===================================

DAC_SPI_RECEIVER -- requirements
Module: dac_spi_receiver

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 24: bits per DAC frame per lane.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on all serial inputs.
REQ-003 The block SHALL have port clk  input  1: single clock, at least 4x the DAC_SCK frequency.
REQ-004 The block SHALL have port reset_n  input  1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port dac_sck  input  1: serial clock from the DAC transmitter.
REQ-006 The block SHALL have port dac_cs_n  input  1: frame select, active-low, common to all 4 lanes.
REQ-007 The block SHALL have port dac_sdo  input  4: one serial data lane per DAC.
REQ-008 The block SHALL have port frame_data  output  4*FRAME_BITS: received words, with lane k at bits [k*FRAME_BITS +: FRAME_BITS].
REQ-009 The block SHALL have port frame_valid  output  1: frame_data holds an unconsumed frame.
REQ-010 The block SHALL have port frame_ready  input  1: consumer accepts the frame.
REQ-011 The block SHALL have port frame_error  output  1: one-cycle pulse when a frame ends with a wrong bit count.
REQ-012 The block SHALL have port overrun  output  1: sticky flag, set when a frame is dropped.
REQ-013 The block SHALL have port clear_status  input  1: clears overrun and frame_count.
REQ-014 The block SHALL have port frame_count  output  16: number of good frames accepted into the output register, wrapping at 16'hFFFF.

Function
REQ-015 All three serial inputs SHALL pass through SYNC_STAGES flip-flops of equal depth before use.
REQ-016 The FSM SHALL have three states:
- IDLE to SHIFT on a synchronized falling edge of cs_n.
- SHIFT to CHECK on a synchronized rising edge of cs_n.
- CHECK to IDLE unconditionally after 1 cycle.
REQ-017 In SHIFT, on each synchronized dac_sck rising edge, each lane SHALL shift the synchronized sdo bit into its register LSB, MSB first, and bit_cnt SHALL increment.
REQ-018 bit_cnt SHALL saturate at FRAME_BITS+1; further sck edges SHALL NOT wrap it.
REQ-019 If an sck rising edge and a cs_n rising edge are detected in the same cycle, the sck bit SHALL be shifted before the frame is checked.
REQ-020 In CHECK, if bit_cnt equals FRAME_BITS, the frame is good; otherwise frame_error SHALL pulse and no data SHALL be delivered.
REQ-021 Good-frame delivery:
- If frame_valid is low, or frame_ready is high in that cycle, frame_data SHALL load on the next clk edge, frame_valid SHALL be 1, and frame_count SHALL increment.
- Otherwise the frame SHALL be dropped, overrun set, frame_data unchanged.
REQ-022 frame_valid SHALL clear on the cycle after frame_valid and frame_ready are both high, unless a new frame loads in that same cycle.
REQ-023 Latency from the dac_cs_n rising edge at the input pin to frame_valid high SHALL be SYNC_STAGES+3 clk cycles.
REQ-024 sck edges while in IDLE SHALL be ignored.
REQ-025 A cs_n falling edge in CHECK SHALL be registered, so the next frame is not lost.
REQ-026 If clear_status and an overrun or count event occur in the same cycle, clear_status SHALL win.

Reset
REQ-027 On reset_n low, these SHALL reset asynchronously: FSM to IDLE, frame_valid=0, frame_error=0, overrun=0, frame_count=0, frame_data=0, bit_cnt=0, synchronizers to idle level (cs_n=1, sck=0, sdo=0).
REQ-028 Reset asserted mid-frame SHALL discard the partial frame, and the first frame after release SHALL start only on a fresh cs_n falling edge.

Structure
REQ-029 The FSM state encoding and the lane count constant (4) SHALL reside in the shared dac_pkg, alongside the constants used by the DAC transmitter.
REQ-030 One sub-module, sync_edge_det_bus, SHALL synchronize the 6 input bits and produce the rise/fall strobes for sck and cs_n; it SHALL be instantiated once.

Verification
REQ-031 Scenario 1: one 24-bit frame with lanes 0xA5A5A5, 0x123456, 0xFFFFFF, 0x000001, SCK = clk/4, ready high -> frame_data matches all lanes, frame_valid is high for 1 cycle at SYNC_STAGES+3 cycles after cs_n rises, frame_count=1.
REQ-032 Scenario 2: a 23-bit frame, then a 25-bit frame -> two frame_error pulses, frame_valid never set, frame_count=0.
REQ-033 Scenario 3: ready held low across two good frames -> the first frame is retained, overrun=1, frame_count=1; clear_status then gives overrun=0 and frame_count=0.
REQ-034 Scenario 4: reset_n asserted after 10 bits, released, then a full frame sent -> exactly one good frame with the correct data.
REQ-035 Scenario 5: back-to-back frames with cs_n high for a single SCK period, ready high -> both frames delivered in order, no error.
REQ-036 Scenario 6: frame_count preloaded near 0xFFFF by 2 frames -> it wraps to 0x0000 with no other side effects.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared DAC link definitions: transmitter framing constants and receiver FSM encoding.
package dac_pkg;

   localparam int unsigned DAC_LANES      = 4;
   localparam int unsigned DAC_FRAME_BITS = 24;
   localparam int unsigned DAC_SCK_DIV    = 4;
   localparam logic [3:0]  DAC_CMD_WRITE  = 4'h3;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_SHIFT = 2'd1,
      RX_CHECK = 2'd2
   } rx_state_t;

endpackage

// File: rtl/sync_edge_det_bus.sv
// Synchronizes sck, cs_n and the sdo lanes through equal-depth chains and
// produces registered edge strobes aligned with the synchronized sdo bits.
module sync_edge_det_bus #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned LANES  = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sck,
   input  logic             cs_n,
   input  logic [LANES-1:0] sdo,
   output logic [LANES-1:0] sdo_sync,
   output logic             sck_rise,
   output logic             cs_rise,
   output logic             cs_fall
);

   localparam int unsigned    W          = LANES + 2;
   // Bus layout {sdo, cs_n, sck}; idle level has only cs_n high.
   localparam logic [W-1:0]   IDLE_LEVEL = W'(2);

   logic [W-1:0] chain [STAGES];
   logic [W-1:0] last;
   logic [W-1:0] held;

   assign last     = chain[STAGES-1];
   assign sdo_sync = held[W-1:2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < STAGES; i++) chain[i] <= IDLE_LEVEL;
         held     <= IDLE_LEVEL;
         sck_rise <= 1'b0;
         cs_rise  <= 1'b0;
         cs_fall  <= 1'b0;
      end else begin
         chain[0] <= {sdo, cs_n, sck};
         for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
         held     <= last;
         sck_rise <= last[0] & ~held[0];
         cs_rise  <= last[1] & ~held[1];
         cs_fall  <= ~last[1] & held[1];
      end
   end

endmodule

// File: rtl/dac_spi_receiver.sv
// Four-lane DAC SPI frame receiver: shifts lanes under cs_n, checks the bit
// count, and hands good frames to a valid/ready consumer with overrun tracking.
module dac_spi_receiver
   import dac_pkg::*;
#(
   parameter int unsigned FRAME_BITS  = 24,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            dac_sck,
   input  logic                            dac_cs_n,
   input  logic [DAC_LANES-1:0]            dac_sdo,
   output logic [DAC_LANES*FRAME_BITS-1:0] frame_data,
   output logic                            frame_valid,
   input  logic                            frame_ready,
   output logic                            frame_error,
   output logic                            overrun,
   input  logic                            clear_status,
   output logic [15:0]                     frame_count
);

   localparam int unsigned      CNT_W    = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

   logic [DAC_LANES-1:0]  sdo_sync;
   logic                  sck_rise;
   logic                  cs_rise;
   logic                  cs_fall;

   rx_state_t             state_q;
   rx_state_t             state_d;
   logic                  start_pending_q;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [FRAME_BITS-1:0] shreg [DAC_LANES];

   logic                  frame_good;
   logic                  frame_bad;
   logic                  load;

   sync_edge_det_bus #(
      .STAGES (SYNC_STAGES),
      .LANES  (DAC_LANES)
   ) u_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .sck      (dac_sck),
      .cs_n     (dac_cs_n),
      .sdo      (dac_sdo),
      .sdo_sync (sdo_sync),
      .sck_rise (sck_rise),
      .cs_rise  (cs_rise),
      .cs_fall  (cs_fall)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= RX_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RX_IDLE:  if (cs_fall || start_pending_q) state_d = RX_SHIFT;
         RX_SHIFT: if (cs_rise) state_d = RX_CHECK;
         RX_CHECK: state_d = RX_IDLE;
         default:  state_d = RX_IDLE;
      endcase
   end

   // A cs_n fall seen during CHECK is remembered so IDLE restarts at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_pending_q <= 1'b0;
         bit_cnt_q       <= '0;
         for (int unsigned k = 0; k < DAC_LANES; k++) shreg[k] <= '0;
      end else begin
         if (state_q == RX_CHECK && cs_fall) start_pending_q <= 1'b1;
         else if (state_q == RX_IDLE)        start_pending_q <= 1'b0;

         if (state_q == RX_IDLE && state_d == RX_SHIFT) begin
            bit_cnt_q <= '0;
            for (int unsigned k = 0; k < DAC_LANES; k++) shreg[k] <= '0;
         end else if (state_q == RX_SHIFT && sck_rise) begin
            for (int unsigned k = 0; k < DAC_LANES; k++)
               shreg[k] <= {shreg[k][FRAME_BITS-2:0], sdo_sync[k]};
            if (bit_cnt_q != CNT_MAX) bit_cnt_q <= bit_cnt_q + 1'b1;
         end
      end
   end

   assign frame_good = (state_q == RX_CHECK) && (bit_cnt_q == CNT_GOOD);
   assign frame_bad  = (state_q == RX_CHECK) && (bit_cnt_q != CNT_GOOD);
   assign load       = frame_good && (!frame_valid || frame_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_data  <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_error <= frame_bad;
         if (load) begin
            for (int unsigned k = 0; k < DAC_LANES; k++)
               frame_data[k*FRAME_BITS +: FRAME_BITS] <= shreg[k];
            frame_valid <= 1'b1;
         end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
         end

         if (clear_status) begin
            overrun     <= 1'b0;
            frame_count <= '0;
         end else begin
            if (frame_good && !load) overrun <= 1'b1;
            if (load) frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed scenarios plus randomized frames against a frame-level reference model.
module tb_dac_spi_receiver;

   localparam int unsigned FB    = 24;
   localparam int unsigned SS    = 2;
   localparam int unsigned DW    = 4 * FB;
   localparam int unsigned NEVER = 32'hFFFF_FFFF;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          dac_sck = 1'b0;
   logic          dac_cs_n = 1'b1;
   logic [3:0]    dac_sdo = '0;
   logic          frame_ready = 1'b1;
   logic          clear_status = 1'b0;
   logic [DW-1:0] frame_data;
   logic          frame_valid;
   logic          frame_error;
   logic          overrun;
   logic [15:0]   frame_count;

   dac_spi_receiver #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .dac_sck      (dac_sck),
      .dac_cs_n     (dac_cs_n),
      .dac_sdo      (dac_sdo),
      .frame_data   (frame_data),
      .frame_valid  (frame_valid),
      .frame_ready  (frame_ready),
      .frame_error  (frame_error),
      .overrun      (overrun),
      .clear_status (clear_status),
      .frame_count  (frame_count)
   );

   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Frame-level model: each completed frame becomes an event due at the
   // clock edge where its outcome must be visible.
   typedef struct {
      int unsigned   due;
      bit            good;
      logic [DW-1:0] data;
   } ev_t;

   ev_t           evq[$];
   int unsigned   cyc = 0;
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_data = '0;
   logic          m_err = 1'b0;
   logic          m_ovr = 1'b0;
   logic [15:0]   m_cnt = '0;

   bit            rand_mode = 1'b0;
   int unsigned   valid_rises = 0;
   int unsigned   err_pulses = 0;
   logic          prev_valid = 1'b0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit   handshake;
      bit   loaded;
      ev_t  ev;
      cyc++;
      if (!reset_n) begin
         m_valid = 1'b0; m_data = '0; m_err = 1'b0; m_ovr = 1'b0; m_cnt = '0;
         evq.delete();
      end else begin
         handshake = m_valid && frame_ready;
         loaded    = 1'b0;
         m_err     = 1'b0;
         if (evq.size() > 0 && evq[0].due == cyc) begin
            ev = evq.pop_front();
            if (!ev.good)                      m_err = 1'b1;
            else if (!m_valid || frame_ready) begin
               m_data = ev.data; m_valid = 1'b1; m_cnt = m_cnt + 16'd1; loaded = 1'b1;
            end else                           m_ovr = 1'b1;
         end
         if (handshake && !loaded) m_valid = 1'b0;
         if (clear_status) begin m_ovr = 1'b0; m_cnt = '0; end
      end
   end

   always @(posedge clk) begin
      #1;
      if (reset_n) begin
         chk("valid", DW'(frame_valid), DW'(m_valid));
         if (m_valid) chk("data", frame_data, m_data);
         chk("error", DW'(frame_error), DW'(m_err));
         chk("overrun", DW'(overrun), DW'(m_ovr));
         chk("count", DW'(frame_count), DW'(m_cnt));
         if (frame_valid && !prev_valid) valid_rises++;
         if (frame_error) err_pulses++;
      end
      prev_valid = frame_valid;
   end

   always @(negedge clk) begin
      if (rand_mode) begin
         frame_ready  = ($urandom_range(0, 3) != 0);
         clear_status = ($urandom_range(0, 63) == 0);
      end
   end

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; dac_cs_n = 1'b1; dac_sck = 1'b0; dac_sdo = '0;
      @(negedge clk);
      chk("rst_valid", DW'(frame_valid), '0);
      chk("rst_data", frame_data, '0);
      chk("rst_error", DW'(frame_error), '0);
      chk("rst_overrun", DW'(overrun), '0);
      chk("rst_count", DW'(frame_count), '0);
      idle(2);
      reset_n = 1'b1;
      idle(3);
   endtask

   // Lane k word sits at words[k*FB +: FB]; bits beyond FB are random filler.
   task automatic send_frame(input logic [DW-1:0] words, input int unsigned nbits,
                             input int unsigned half, input int unsigned abort_at);
      logic [3:0] v;
      ev_t        ev;
      @(negedge clk);
      dac_cs_n = 1'b0;
      for (int unsigned i = 0; i < nbits; i++) begin
         if (i == abort_at) begin
            reset_n = 1'b0; dac_cs_n = 1'b1; dac_sck = 1'b0;
            idle(3);
            reset_n = 1'b1;
            return;
         end
         for (int unsigned k = 0; k < 4; k++)
            v[k] = (i < FB) ? words[k*FB + FB - 1 - i] : 1'($urandom);
         dac_sdo = v;
         dac_sck = 1'b0;
         idle(half);
         dac_sck = 1'b1;
         idle(half);
      end
      dac_sck = 1'b0;
      idle(half);
      dac_cs_n = 1'b1;
      ev.due  = cyc + SS + 3;
      ev.good = (nbits == FB);
      ev.data = words;
      evq.push_back(ev);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not complete, required finish before %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] w1, w3a, w3b, w4, w5a, w5b, wr;
      int unsigned   lat, e0, v0, nb;
      w1  = {24'h000001, 24'hFFFFFF, 24'h123456, 24'hA5A5A5};
      w3a = {24'h111111, 24'h222222, 24'h333333, 24'h444444};
      w3b = {24'hDEADBE, 24'hEF0123, 24'h456789, 24'hABCDEF};
      w4  = {24'hC0FFEE, 24'h0BADF0, 24'h5A5A5A, 24'h800001};
      w5a = {24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
      w5b = {24'hF0E0D0, 24'hC0B0A0, 24'h908070, 24'h605040};

      // Scenario 1: single frame, latency and content
      do_reset();
      frame_ready = 1'b1;
      send_frame(w1, FB, 2, NEVER);
      lat = 0;
      for (int unsigned t = 1; t <= 20; t++) begin
         @(posedge clk); #2;
         if (frame_valid) begin lat = t; break; end
      end
      chk("s1_latency", DW'(lat), DW'(SS + 3));
      chk("s1_data", frame_data, {24'h000001, 24'hFFFFFF, 24'h123456, 24'hA5A5A5});
      chk("s1_count", DW'(frame_count), DW'(16'd1));
      @(posedge clk); #2;
      chk("s1_valid_one_cycle", DW'(frame_valid), '0);

      // Scenario 2: short and long frames
      do_reset();
      e0 = err_pulses; v0 = valid_rises;
      send_frame(w1, FB - 1, 2, NEVER);
      idle(6);
      send_frame(w1, FB + 1, 2, NEVER);
      idle(12);
      chk("s2_err_pulses", DW'(err_pulses - e0), DW'(2));
      chk("s2_no_valid", DW'(valid_rises - v0), '0);
      chk("s2_count", DW'(frame_count), '0);

      // Scenario 3: consumer stalled across two frames
      do_reset();
      frame_ready = 1'b0;
      send_frame(w3a, FB, 2, NEVER);
      idle(6);
      send_frame(w3b, FB, 2, NEVER);
      idle(12);
      chk("s3_overrun", DW'(overrun), DW'(1));
      chk("s3_count", DW'(frame_count), DW'(16'd1));
      chk("s3_retained", frame_data, {24'h111111, 24'h222222, 24'h333333, 24'h444444});
      clear_status = 1'b1;
      @(negedge clk);
      clear_status = 1'b0;
      chk("s3_clr_overrun", DW'(overrun), '0);
      chk("s3_clr_count", DW'(frame_count), '0);
      chk("s3_still_valid", DW'(frame_valid), DW'(1));
      frame_ready = 1'b1;
      idle(3);

      // Scenario 4: reset mid-frame
      do_reset();
      send_frame(w4, FB, 2, 10);
      idle(6);
      v0 = valid_rises; e0 = err_pulses;
      send_frame(w4, FB, 2, NEVER);
      idle(12);
      chk("s4_one_frame", DW'(valid_rises - v0), DW'(1));
      chk("s4_no_error", DW'(err_pulses - e0), '0);
      chk("s4_data", frame_data, {24'hC0FFEE, 24'h0BADF0, 24'h5A5A5A, 24'h800001});
      chk("s4_count", DW'(frame_count), DW'(16'd1));

      // Scenario 5: back-to-back with one SCK period between frames
      do_reset();
      v0 = valid_rises; e0 = err_pulses;
      send_frame(w5a, FB, 2, NEVER);
      idle(3);
      send_frame(w5b, FB, 2, NEVER);
      idle(12);
      chk("s5_two_frames", DW'(valid_rises - v0), DW'(2));
      chk("s5_no_error", DW'(err_pulses - e0), '0);
      chk("s5_last_data", frame_data, {24'hF0E0D0, 24'hC0B0A0, 24'h908070, 24'h605040});
      chk("s5_count", DW'(frame_count), DW'(16'd2));

      // Scenario 6: frame_count wrap from a preloaded value
      do_reset();
      @(negedge clk);
      force dut.frame_count = 16'hFFFE;
      m_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.frame_count;
      e0 = err_pulses;
      send_frame(w1, FB, 2, NEVER);
      idle(8);
      chk("s6_count_ffff", DW'(frame_count), DW'(16'hFFFF));
      send_frame(w5a, FB, 2, NEVER);
      idle(12);
      chk("s6_count_wrap", DW'(frame_count), '0);
      chk("s6_overrun", DW'(overrun), '0);
      chk("s6_no_error", DW'(err_pulses - e0), '0);

      // Randomized frames, bit counts, ready and clear patterns
      do_reset();
      rand_mode = 1'b1;
      for (int unsigned n = 0; n < 40; n++) begin
         wr = {$urandom, $urandom, $urandom};
         case ($urandom_range(0, 9))
            0:       nb = FB - 1;
            1:       nb = FB + 1;
            2:       nb = 0;
            3:       nb = FB + 6;
            default: nb = FB;
         endcase
         send_frame(wr, nb, $urandom_range(2, 3), NEVER);
         idle($urandom_range(2, 8));
      end
      idle(12);
      rand_mode = 1'b0;
      @(negedge clk);
      clear_status = 1'b0;
      frame_ready  = 1'b1;
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
